// File: rtl/sort_drain.sv
// Drains the odd-even transposition sorter output: waits a settle interval after load,
// snapshots the flat result bus and streams it out over valid/ready with an order check.
module sort_drain #(
    parameter int array_len     = 12,
    parameter int int_len       = 32,
    parameter int settle_cycles = array_len + 2,
    parameter int idx_w         = $clog2(array_len)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [array_len*int_len-1:0] sorted_array,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [int_len-1:0]           out_data,
    output logic [idx_w-1:0]             out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         order_err,
    output logic                         aborted
);

    localparam int                 cnt_w    = $clog2(settle_cycles + 1);
    localparam logic [cnt_w-1:0]   cnt_max  = cnt_w'(settle_cycles - 1);
    localparam logic [idx_w-1:0]   last_idx = idx_w'(array_len - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, STREAM} state_t;

    state_t             state_reg, state_next;
    logic [cnt_w-1:0]   cnt_reg, cnt_next;
    logic [idx_w-1:0]   idx_reg, idx_next;
    logic [int_len-1:0] prev_reg, prev_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;
    logic               aborted_reg, aborted_next;
    logic               capture;

    logic [int_len-1:0] in_elem  [array_len];
    logic [int_len-1:0] snap_reg [array_len];
    logic [int_len-1:0] cur_data;

    // Unpack the flat sorter bus into addressable elements.
    for (genvar gi = 0; gi < array_len; gi++) begin : g_unpack
        assign in_elem[gi] = sorted_array[int_len*gi +: int_len];
    end

    assign cur_data = snap_reg[idx_reg];

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        prev_next    = prev_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    state_next = SETTLE;
                    cnt_next   = cnt_max;
                    err_next   = 1'b0;
                end
            end
            SETTLE: begin
                if (load) begin
                    cnt_next = cnt_max;
                end else if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = STREAM;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STREAM: begin
                // A new load beats any handshake, including the final one.
                if (load) begin
                    aborted_next = 1'b1;
                    state_next   = SETTLE;
                    cnt_next     = cnt_max;
                    err_next     = 1'b0;
                end else if (out_ready) begin
                    if (idx_reg != '0 && cur_data < prev_reg)
                        err_next = 1'b1;
                    prev_next = cur_data;
                    if (idx_reg == last_idx) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            prev_reg    <= '0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            prev_reg    <= prev_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < array_len; i++) begin
            if (rst)
                snap_reg[i] <= '0;
            else if (capture)
                snap_reg[i] <= in_elem[i];
        end
    end

    // Beat fields are forced to zero outside STREAM so idle outputs read as 0.
    assign out_valid = (state_reg == STREAM);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_valid ? cur_data : '0;
    assign out_index = out_valid ? idx_reg : '0;
    assign out_last  = out_valid && (idx_reg == last_idx);
    assign done      = done_reg;
    assign order_err = err_reg;
    assign aborted   = aborted_reg;

endmodule

// File: tb/tb_sort_drain.sv
// Directed bench for sort_drain with a 4 x 8-bit array and a 6-cycle settle interval.
module tb_sort_drain;

    localparam int AL = 4;
    localparam int IL = 8;
    localparam int SC = 6;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [AL*IL-1:0] sorted_array;
    logic          out_valid;
    logic          out_ready;
    logic [IL-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          order_err;
    logic          aborted;

    int checks = 0;
    int errors = 0;

    sort_drain #(.array_len(AL), .int_len(IL), .settle_cycles(SC), .idx_w(IW)) dut (
        .clk(clk), .rst(rst), .load(load), .sorted_array(sorted_array),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .order_err(order_err), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Counts cycles until out_valid, bounded; called one cycle after load was sampled.
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(SC));
    endtask

    // Accepts all four beats with out_ready held high; vals = {d3,d2,d1,d0}.
    task automatic drain_all(input string tag, input logic [31:0] vals);
        logic [31:0] v;
        v = vals;
        out_ready = 1'b1;
        for (int i = 0; i < AL; i++) begin
            check({tag, "_idx"}, 64'(out_index), 64'(i));
            check({tag, "_data"}, 64'(out_data), 64'(v[IL*i +: IL]));
            check({tag, "_last"}, 64'(out_last), 64'(i == AL - 1));
            $display("beat %s idx=%0d data=%0d last=%0b err=%0b", tag, out_index, out_data, out_last, order_err);
            tick();
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_vdrop"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [6:0] pat;
        int exp_idx;
        int xfers;
        int vcount;
        logic [31:0] uns;

        rst = 1'b1; load = 1'b0; out_ready = 1'b0;
        sorted_array = {8'd3, 8'd2, 8'd1, 8'd0};
        tick(); tick();
        load = 1'b1;               // reset must win over load
        tick();
        load = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({out_data, out_index, out_last, done, order_err, aborted}), 64'd0);
        rst = 1'b0;
        tick();

        // 1. Basic drain
        out_ready = 1'b1;
        pulse_load();
        check("t1_busy", 64'(busy), 64'd1);
        wait_valid("t1_latency");
        drain_all("t1", {8'd3, 8'd2, 8'd1, 8'd0});
        check("t1_err", 64'(order_err), 64'd0);

        // 2. Backpressure: ready pattern 1,0,0,1,1,0,1 (bit 0 first)
        out_ready = 1'b0;
        pulse_load();
        wait_valid("t2_latency");
        pat = 7'b1011001;
        exp_idx = 0;
        xfers = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            check("t2_idx", 64'(out_index), 64'(exp_idx));
            check("t2_data", 64'(out_data), 64'(exp_idx));
            $display("beat t2 cyc=%0d idx=%0d data=%0d ready=%0b", k, out_index, out_data, out_ready);
            tick();
            if (pat[k]) begin
                exp_idx++;
                xfers++;
            end
        end
        check("t2_xfers", 64'(xfers), 64'd4);
        check("t2_done", 64'(done), 64'd1);
        out_ready = 1'b0;
        tick();

        // 3. Unsorted input: beats 1,7,5,9; error visible after beat carrying 5
        sorted_array = {8'd9, 8'd5, 8'd7, 8'd1};
        pulse_load();
        wait_valid("t3_latency");
        uns = {8'd9, 8'd5, 8'd7, 8'd1};
        out_ready = 1'b1;
        for (int i = 0; i < AL; i++) begin
            check("t3_data", 64'(out_data), 64'(uns[IL*i +: IL]));
            check("t3_err", 64'(order_err), 64'(i == 3));
            $display("beat t3 idx=%0d data=%0d err=%0b", out_index, out_data, order_err);
            tick();
        end
        check("t3_done", 64'(done), 64'd1);
        check("t3_err_sticky", 64'(order_err), 64'd1);
        tick();
        check("t3_err_hold", 64'(order_err), 64'd1);

        // 4. Load during SETTLE restarts the interval; the new load clears order_err
        sorted_array = {8'd3, 8'd2, 8'd1, 8'd0};
        pulse_load();
        check("t4_err_clr", 64'(order_err), 64'd0);
        tick(); tick();
        check("t4_no_valid", 64'(out_valid), 64'd0);
        pulse_load();
        wait_valid("t4_latency");
        drain_all("t4", {8'd3, 8'd2, 8'd1, 8'd0});

        // 5. Load during STREAM after two accepted beats
        pulse_load();
        wait_valid("t5_latency");
        out_ready = 1'b1;
        tick(); tick();
        check("t5_idx2", 64'(out_index), 64'd2);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("t5_aborted", 64'(aborted), 64'd1);
        check("t5_vdrop", 64'(out_valid), 64'd0);
        check("t5_nodone", 64'(done), 64'd0);
        check("t5_busy", 64'(busy), 64'd1);
        $display("abort t5 aborted=%0b valid=%0b done=%0b", aborted, out_valid, done);
        wait_valid("t5_relatency");
        check("t5_abort_pulse", 64'(aborted), 64'd0);
        // Snapshot must ignore bus changes during STREAM
        sorted_array = {8'd40, 8'd30, 8'd20, 8'd10};
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("t5_snap_idx", 64'(out_index), 64'd3);
        check("t5_snap_data", 64'(out_data), 64'd3);
        // Load together with the last handshake: abort wins, no done
        load = 1'b1;
        tick();
        load = 1'b0;
        check("t5_last_abort", 64'(aborted), 64'd1);
        check("t5_last_nodone", 64'(done), 64'd0);
        $display("abort t5b aborted=%0b done=%0b", aborted, done);

        // 6. Reset mid-stream during beat 1
        wait_valid("t6_latency");
        check("t6_new_snap", 64'(out_data), 64'd10);
        tick();
        check("t6_beat1", 64'(out_index), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_outs", 64'({out_data, out_index, out_last, done, order_err, aborted}), 64'd0);
        sorted_array = {8'd1, 8'd2, 8'd3, 8'd4};
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid || busy) vcount++;
        end
        check("t6_idle", 64'(vcount), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
